// File: rtl/viterbi_pkg.sv
// Shared types and width helpers for the convolutional encoder / Viterbi pair.
package viterbi_pkg;

  localparam int N_DEF  = 2;
  localparam int K_DEF  = 1;
  localparam int M_DEF  = 4;
  localparam int L_DEF  = 7;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fsm_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  localparam int SW_DEF = M_DEF - K_DEF;
  localparam int CW_DEF = max1(clog2(L_DEF));
  localparam int EW_DEF = clog2(L_DEF * N_DEF) + 1;

endpackage

// File: rtl/conv_table.sv
// Resettable Next State / Output register file, one write port and
// one combinational read port indexed by (state, input).
module conv_table
  import viterbi_pkg::*;
#(
  parameter int n = N_DEF,
  parameter int k = K_DEF,
  parameter int m = M_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic [0:m-k-1] wr_state,
  input  logic [0:k-1]   wr_input,
  input  logic [0:m-k-1] wr_next,
  input  logic [0:n-1]   wr_out,
  input  logic [0:m-k-1] rd_state,
  input  logic [0:k-1]   rd_input,
  output logic [0:m-k-1] rd_next,
  output logic [0:n-1]   rd_out
);

  localparam int DEPTH = 1 << m;

  logic [0:m-k-1] ns_q  [DEPTH];
  logic [0:m-k-1] ns_d  [DEPTH];
  logic [0:n-1]   out_q [DEPTH];
  logic [0:n-1]   out_d [DEPTH];

  logic [m-1:0] widx;
  logic [m-1:0] ridx;

  assign widx = {wr_state, wr_input};
  assign ridx = {rd_state, rd_input};

  always_comb begin
    ns_d  = ns_q;
    out_d = out_q;
    if (load) begin
      ns_d[widx]  = wr_next;
      out_d[widx] = wr_out;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ns_q[i]  <= '0;
        out_q[i] <= '0;
      end
    end else begin
      ns_q  <= ns_d;
      out_q <= out_d;
    end
  end

  assign rd_next = ns_q[ridx];
  assign rd_out  = out_q[ridx];

endmodule

// File: rtl/conv_frame_encoder.sv
// Frame-based table-driven convolutional encoder (L symbols per start).
// Optional error injector enabled by defining CONV_ERROR_INJECT_EN.
module conv_frame_encoder
  import viterbi_pkg::*;
#(
  parameter int n = N_DEF,
  parameter int k = K_DEF,
  parameter int m = M_DEF,
  parameter int L = L_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       restart,
  input  logic                       enable,
  input  logic                       load,
  input  logic [0:m-k-1]             state_address,
  input  logic [0:k-1]               input_address,
  input  logic [0:m-k-1]             next_state_data,
  input  logic [0:n-1]               output_data,
  input  logic                       start,
  input  logic [0:k*L-1]             message,
`ifdef CONV_ERROR_INJECT_EN
  input  logic [0:n-1]               err_mask,
  output logic [clog2(L*n):0]        inj_count,
`endif
  output logic [0:n-1]               encoded,
  output logic                       encoded_valid,
  output logic                       busy,
  output logic                       done
);

  localparam int S  = m - k;
  localparam int CW = max1(clog2(L));
  localparam int MW = k * L;
  localparam logic [CW-1:0] LAST = CW'(L - 1);

  fsm_state_e     st_q, st_d;
  logic [0:S-1]   cur_q, cur_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [0:MW-1]  msg_q, msg_d;
  logic [0:n-1]   enc_q, enc_d;
  logic           vld_q, vld_d;
  logic           done_q, done_d;

  logic [0:S-1]   tbl_next;
  logic [0:n-1]   tbl_out;
  logic [0:n-1]   sym;
  logic [0:k-1]   in_bits;

  // The message shifts toward index 0, so the live symbol is always the head.
  assign in_bits = msg_q[0:k-1];

`ifdef CONV_ERROR_INJECT_EN
  localparam int IW = clog2(L * n) + 1;
  logic [IW-1:0] inj_q, inj_d;
  assign sym       = tbl_out ^ err_mask;
  assign inj_count = inj_q;
`else
  assign sym = tbl_out;
`endif

  conv_table #(
    .n(n),
    .k(k),
    .m(m)
  ) u_table (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .wr_state (state_address),
    .wr_input (input_address),
    .wr_next  (next_state_data),
    .wr_out   (output_data),
    .rd_state (cur_q),
    .rd_input (in_bits),
    .rd_next  (tbl_next),
    .rd_out   (tbl_out)
  );

  always_comb begin
    st_d   = st_q;
    cur_d  = cur_q;
    cnt_d  = cnt_q;
    msg_d  = msg_q;
    enc_d  = enc_q;
    vld_d  = 1'b0;
    done_d = 1'b0;
`ifdef CONV_ERROR_INJECT_EN
    inj_d  = inj_q;
`endif
    if (restart) begin
      st_d  = IDLE;
      cnt_d = '0;
`ifdef CONV_ERROR_INJECT_EN
      inj_d = '0;
`endif
    end else begin
      unique case (st_q)
        IDLE: begin
          if (start) begin
            st_d  = RUN;
            msg_d = message;
            cur_d = '0;
            cnt_d = '0;
`ifdef CONV_ERROR_INJECT_EN
            inj_d = '0;
`endif
          end
        end
        RUN: begin
          if (enable) begin
            enc_d = sym;
            vld_d = 1'b1;
            cur_d = tbl_next;
            cnt_d = cnt_q + 1'b1;
            msg_d = msg_q << k;
`ifdef CONV_ERROR_INJECT_EN
            inj_d = inj_q + IW'($countones(err_mask));
`endif
            if (cnt_q == LAST) begin
              done_d = 1'b1;
              cnt_d  = '0;
              // A start seen on the final issue chains the next frame gaplessly.
              if (start) begin
                msg_d = message;
                cur_d = '0;
`ifdef CONV_ERROR_INJECT_EN
                inj_d = '0;
`endif
              end else begin
                st_d = IDLE;
              end
            end
          end
        end
        default: st_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q   <= IDLE;
      cur_q  <= '0;
      cnt_q  <= '0;
      msg_q  <= '0;
      enc_q  <= '0;
      vld_q  <= 1'b0;
      done_q <= 1'b0;
`ifdef CONV_ERROR_INJECT_EN
      inj_q  <= '0;
`endif
    end else begin
      st_q   <= st_d;
      cur_q  <= cur_d;
      cnt_q  <= cnt_d;
      msg_q  <= msg_d;
      enc_q  <= enc_d;
      vld_q  <= vld_d;
      done_q <= done_d;
`ifdef CONV_ERROR_INJECT_EN
      inj_q  <= inj_d;
`endif
    end
  end

  assign encoded       = enc_q;
  assign encoded_valid = vld_q;
  assign busy          = (st_q == RUN);
  assign done          = done_q;

endmodule

// File: tb/tb_conv_frame_encoder.sv
// Randomized bench for conv_frame_encoder with an in-bench frame model.
module tb_conv_frame_encoder;

  localparam int N = 2;
  localparam int K = 1;
  localparam int M = 4;
  localparam int L = 7;
  localparam int S = M - K;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           restart = 1'b0;
  logic           enable = 1'b1;
  logic           load = 1'b0;
  logic [0:S-1]   state_address = '0;
  logic [0:K-1]   input_address = '0;
  logic [0:S-1]   next_state_data = '0;
  logic [0:N-1]   output_data = '0;
  logic           start = 1'b0;
  logic [0:K*L-1] message = '0;
  logic [0:N-1]   encoded;
  logic           encoded_valid;
  logic           busy;
  logic           done;
`ifdef CONV_ERROR_INJECT_EN
  logic [0:N-1]   err_mask = '0;
  logic [4:0]     inj_count;
  int             inj_at_done = 0;
`endif

  conv_frame_encoder #(.n(N), .k(K), .m(M), .L(L)) dut (
    .clk             (clk),
    .reset           (reset),
    .restart         (restart),
    .enable          (enable),
    .load            (load),
    .state_address   (state_address),
    .input_address   (input_address),
    .next_state_data (next_state_data),
    .output_data     (output_data),
    .start           (start),
    .message         (message),
`ifdef CONV_ERROR_INJECT_EN
    .err_mask        (err_mask),
    .inj_count       (inj_count),
`endif
    .encoded         (encoded),
    .encoded_valid   (encoded_valid),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tables as arrays, frame as (message, symbol index).
  int             m_ns  [8][2];
  int             m_out [8][2];
  bit             m_run = 0;
  int             m_t = 0;
  int             m_cur = 0;
  int             m_in = 0;
  logic [0:K*L-1] m_msg = '0;
  int             e_enc = 0;
  bit             e_vld = 0;
  bit             e_done = 0;
  bit             e_busy = 0;
  int             e_inj = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < 8; s++)
        for (int i = 0; i < 2; i++) begin
          m_ns[s][i]  = 0;
          m_out[s][i] = 0;
        end
      m_run = 0; m_t = 0; m_cur = 0;
      e_enc = 0; e_vld = 0; e_done = 0; e_busy = 0; e_inj = 0;
    end else begin
      e_vld  = 0;
      e_done = 0;
      if (restart) begin
        m_run = 0; m_t = 0; e_inj = 0;
      end else if (!m_run) begin
        if (start) begin
          m_run = 1; m_msg = message; m_cur = 0; m_t = 0; e_inj = 0;
        end
      end else if (enable) begin
        m_in  = int'(m_msg[m_t]);
        e_enc = m_out[m_cur][m_in];
`ifdef CONV_ERROR_INJECT_EN
        e_enc = e_enc ^ int'(err_mask);
        e_inj = e_inj + $countones(err_mask);
`endif
        e_vld = 1;
        m_cur = m_ns[m_cur][m_in];
        m_t++;
        if (m_t == L) begin
          e_done = 1;
          m_t = 0;
          if (start) begin
            m_msg = message; m_cur = 0; e_inj = 0;
          end else begin
            m_run = 0;
          end
        end
      end
      if (load) begin
        m_ns[state_address][input_address]  = int'(next_state_data);
        m_out[state_address][input_address] = int'(output_data);
      end
      e_busy = m_run;
    end
  end

  // Cycle compare plus capture of issued symbols for directed checks.
  logic [0:N-1] got[$];
  int n_done = 0;
  int run_len = 0;
  int max_run = 0;

  always @(negedge clk) begin
    check("encoded", 32'(encoded), 32'(e_enc));
    check("encoded_valid", 32'(encoded_valid), 32'(e_vld));
    check("busy", 32'(busy), 32'(e_busy));
    check("done", 32'(done), 32'(e_done));
`ifdef CONV_ERROR_INJECT_EN
    check("inj_count", 32'(inj_count), 32'(e_inj));
    if (done) inj_at_done = int'(inj_count);
`endif
    if (encoded_valid) begin
      got.push_back(encoded);
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else begin
      run_len = 0;
    end
    if (done) n_done++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_syms(input int nsym, input string nm);
    int c;
    c = 0;
    while (got.size() < nsym && c < 60) begin
      tick();
      c++;
    end
    check(nm, 32'(got.size()), 32'(nsym));
  endtask

  task automatic load_75();
    logic [0:2] sv;
    logic       b;
    for (int s = 0; s < 8; s++)
      for (int i = 0; i < 2; i++) begin
        sv = 3'(s);
        b  = 1'(i);
        load            = 1'b1;
        state_address   = sv;
        input_address   = b;
        next_state_data = {sv[1], sv[2], b};
        output_data     = {b ^ sv[2] ^ sv[1], b ^ sv[1]};
        tick();
      end
    load = 1'b0;
  endtask

  task automatic begin_frame(input logic [0:K*L-1] msg);
    got.delete();
    start   = 1'b1;
    message = msg;
    tick();
    start = 1'b0;
  endtask

  task automatic check_impulse(input string nm);
    logic [0:N-1] ref_sym [7];
    ref_sym = '{2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    for (int i = 0; i < 7; i++)
      if (i < got.size())
        check($sformatf("%s_sym%0d", nm, i), 32'(got[i]), 32'(ref_sym[i]));
  endtask

  localparam logic [0:K*L-1] IMPULSE = 7'b1000000;

  initial begin
    int d0;
    #1 reset = 1'b1;
    tick();
    check("rst_encoded", 32'(encoded), 32'd0);
    check("rst_valid", 32'(encoded_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    tick();

    load_75();

    begin_frame('0);
    wait_syms(7, "zero_len");
    for (int i = 0; i < 7; i++)
      if (i < got.size()) check("zero_sym", 32'(got[i]), 32'd0);
    tick();
    check("zero_idle", 32'(busy), 32'd0);

    begin_frame(IMPULSE);
    wait_syms(7, "imp_len");
    check_impulse("imp");
    tick();

    begin_frame(IMPULSE);
    wait_syms(2, "stall_pre");
    enable = 1'b0;
    repeat (3) tick();
    check("stall_hold", 32'(got.size()), 32'd2);
    enable = 1'b1;
    wait_syms(7, "stall_len");
    tick();
    check("stall_nodup", 32'(got.size()), 32'd7);
    check_impulse("stall");

    d0 = n_done;
    begin_frame(IMPULSE);
    wait_syms(4, "rst_pre");
    restart = 1'b1;
    start   = 1'b1;
    tick();
    restart = 1'b0;
    start   = 1'b0;
    repeat (4) tick();
    check("restart_cnt", 32'(got.size()), 32'd4);
    check("restart_busy", 32'(busy), 32'd0);
    check("restart_nodone", 32'(n_done), 32'(d0));
    begin_frame(IMPULSE);
    wait_syms(7, "rerun_len");
    check_impulse("rerun");
    tick();

    max_run = 0;
    begin_frame(IMPULSE);
    wait_syms(6, "b2b_pre");
    start   = 1'b1;
    message = '0;
    tick();
    start = 1'b0;
    wait_syms(14, "b2b_len");
    tick();
    check("b2b_contig", 32'(max_run), 32'd14);

    begin_frame(IMPULSE);
    wait_syms(3, "mid_pre");
    reset = 1'b1;
    #1;
    check("mid_rst_enc", 32'(encoded), 32'd0);
    check("mid_rst_vld", 32'(encoded_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    begin_frame(IMPULSE);
    wait_syms(7, "clr_len");
    for (int i = 0; i < 7; i++)
      if (i < got.size()) check("clr_sym", 32'(got[i]), 32'd0);
    tick();

    load_75();
    for (int c = 0; c < 500; c++) begin
      enable          = ($urandom_range(0, 3) != 0);
      start           = ($urandom_range(0, 4) == 0);
      restart         = ($urandom_range(0, 29) == 0);
      load            = ($urandom_range(0, 9) == 0);
      state_address   = 3'($urandom);
      input_address   = 1'($urandom);
      next_state_data = 3'($urandom);
      output_data     = 2'($urandom);
      message         = 7'($urandom);
`ifdef CONV_ERROR_INJECT_EN
      err_mask        = 2'($urandom);
`endif
      tick();
    end
    start   = 1'b0;
    load    = 1'b0;
    enable  = 1'b1;
    restart = 1'b1;
`ifdef CONV_ERROR_INJECT_EN
    err_mask = '0;
`endif
    tick();
    restart = 1'b0;
    tick();

`ifdef CONV_ERROR_INJECT_EN
    load_75();
    begin_frame('0);
    for (int c = 0; c < 40 && got.size() < 7; c++) begin
      err_mask = (got.size() == 1 || got.size() == 4) ? 2'b01 : 2'b00;
      tick();
    end
    err_mask = '0;
    check("inj_len", 32'(got.size()), 32'd7);
    if (got.size() == 7) begin
      check("inj_sym2", 32'(got[1]), 32'd1);
      check("inj_sym5", 32'(got[4]), 32'd1);
      check("inj_sym3", 32'(got[2]), 32'd0);
    end
    check("inj_done_cnt", 32'(inj_at_done), 32'd2);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
